// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: packed-word output stream (FWFT valid/ready) with frame-last marker
interface adc_frame_packer_if;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    modport master (output out_data_o, out_valid_o, out_last_o, input out_ready_i);
    modport slave  (input out_data_o, out_valid_o, out_last_o, output out_ready_i);
endinterface

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs channel-interleaved ADC samples into 32-bit words, whole frames
// into an FWFT FIFO; frames that do not fit or are broken by resync are dropped and counted.
module adc_frame_packer #(
    parameter int AdcRes    = 14,
    parameter int NumCh     = 2,
    parameter int FifoDepth = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [AdcRes-1:0] adc_data_i,
    input  logic              adc_valid_i,
    input  logic              sync_i,
    input  logic              fmt_offset_bin_i,
    input  logic              test_mode_i,
    adc_frame_packer_if.master stream,
    output logic              overflow_o,
    input  logic              ovf_clr_i,
    output logic [15:0]       drop_cnt_o
);
    localparam int W   = (NumCh + 1) / 2;
    localparam int ChW = NumCh > 1 ? $clog2(NumCh) : 1;
    localparam int WiW = W > 1 ? $clog2(W) : 1;
    localparam int AW  = $clog2(FifoDepth);

    typedef enum logic {IDLE, WRITE} state_t;
    state_t state_q, state_d;

    logic [ChW-1:0]    ch_q, ch_eff;
    logic [AdcRes-1:0] ramp_q, raw;
    logic [15:0]       slot_q [2*W];
    logic [WiW-1:0]    widx_q, widx_d;
    logic [AW:0]       cnt_q;
    logic [AW-1:0]     wp_q, rp_q;
    logic [32:0]       mem [FifoDepth];
    logic [31:0]       wr_word;
    logic              rd, wr_en, wr_last, last_word, done, go, drop_full, resync, drop_ev;
    int                free;

    assign ch_eff    = sync_i ? '0 : ch_q;
    assign raw       = test_mode_i ? ramp_q + AdcRes'(ch_eff)
                                   : adc_data_i ^ {fmt_offset_bin_i, {(AdcRes-1){1'b0}}};
    assign done      = adc_valid_i && ch_eff == ChW'(NumCh - 1);
    assign resync    = adc_valid_i && sync_i && ch_q != '0;
    assign rd        = stream.out_valid_o && stream.out_ready_i;
    // Space still owed to an in-flight frame is not free, but a read on this edge is.
    assign free      = FifoDepth - int'(cnt_q) + int'(rd) - (state_q == WRITE ? W - int'(widx_q) : 0);
    assign go        = done && free >= W;
    assign drop_full = done && free < W;
    assign drop_ev   = drop_full || resync;
    assign last_word = widx_q == WiW'(W - 1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE || last_word) ? (go ? WRITE : IDLE) : WRITE;
        widx_d  = (state_q == WRITE && !last_word) ? widx_q + 1'b1 : '0;
    end

    always_comb begin
        wr_en   = state_q == WRITE;
        wr_word = {slot_q[{widx_q, 1'b1}], slot_q[{widx_q, 1'b0}]};
        wr_last = last_word;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ch_q       <= '0;
            ramp_q     <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            for (int i = 0; i < 2*W; i++) slot_q[i] <= '0;
        end else begin
            if (adc_valid_i) begin
                slot_q[ch_eff] <= 16'($signed(raw));
                ch_q           <= done ? '0 : ch_eff + 1'b1;
            end
            if (done) ramp_q <= ramp_q + 1'b1;
            overflow_o <= drop_full | (overflow_o & ~ovf_clr_i);
            drop_cnt_o <= ovf_clr_i ? {15'd0, drop_ev}
                        : (drop_ev && drop_cnt_o != 16'hFFFF) ? drop_cnt_o + 1'b1 : drop_cnt_o;
        end
    end

    always_ff @(posedge clk_i) if (wr_en) mem[wp_q] <= {wr_last, wr_word};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd);
        end
    end

    assign stream.out_valid_o = cnt_q != '0;
    assign stream.out_data_o  = stream.out_valid_o ? mem[rp_q][31:0] : '0;
    assign stream.out_last_o  = stream.out_valid_o && mem[rp_q][32];
endmodule
